result_display_scanner: RTL

//   Downstream display stage for the calculator datapath. Accepts the 8-bit

---
 rtl/calc_display_pkg.sv | 29 ++
 rtl/seg7_decode.sv | 19 +
 rtl/result_display_scanner.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/calc_display_pkg.sv
// Shared definitions for the calculator display path: FSM encoding,
// BCD digit container and the common-anode 7-segment constant table.
package calc_display_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0] hund;
    logic [3:0] tens;
    logic [3:0] ones;
  } bcd3_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segments {g,f,e,d,c,b,a}, active-low; element i is the pattern for digit i.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern with a blank override.
// Codes above 9 never occur on this path and are shown blank.
module seg7_decode
  import calc_display_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
    o_seg = SEG_BLANK;
    if (!i_blank && (i_digit <= 4'd9)) begin
      o_seg = SEG_TABLE[i_digit];
    end
  end

endmodule

// File: rtl/result_display_scanner.sv
// Sequential double-dabble conversion of an 8-bit result with a one-deep hold
// buffer, feeding a registered, leading-zero-blanked 4-digit scan display.
module result_display_scanner
  import calc_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DIV_W       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] result,
  input  logic       result_valid,
  output logic       busy,
  output logic       done,
  output logic [3:0] an,
  output logic [6:0] seg
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(REFRESH_DIV - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic             w_start;

  logic [7:0]       r_bin;
  bcd3_t            r_bcd;
  logic [2:0]       r_bit_cnt;
  logic             r_hold_vld;
  logic [7:0]       r_hold_val;
  bcd3_t            r_shown;

  logic [DIV_W-1:0] r_presc;
  logic [1:0]       r_idx;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;

  logic [7:0]       w_load_val;
  logic             w_last_bit;
  bcd3_t            w_bcd_adj;
  bcd3_t            w_bcd_shift;
  logic             w_wrap;
  logic             w_refresh;
  logic [1:0]       w_idx_next;
  logic [3:0]       w_digit;
  logic             w_blank;
  logic [3:0]       w_an;
  logic [6:0]       w_seg;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: asynchronous active-low reset; sequential state is always updated with non-blocking assignments.
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (result_valid || r_hold_vld) begin
          w_state_next = CONV;
          w_start      = 1'b1;
        end
      end
      CONV: begin
        busy = 1'b1;
        if (r_bit_cnt == 3'd7) begin
          w_state_next = COMMIT;
        end
      end
      COMMIT: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- double-dabble datapath and hold buffer ----------------
  assign w_load_val = result_valid ? result : r_hold_val;
  assign w_last_bit = (r_state == CONV) && (r_bit_cnt == 3'd7);

  always_comb begin
    w_bcd_adj.hund = add3_if_ge5(r_bcd.hund);
    w_bcd_adj.tens = add3_if_ge5(r_bcd.tens);
    w_bcd_adj.ones = add3_if_ge5(r_bcd.ones);
    // Hundreds never exceeds 2, so the bit shifted out of the top is always 0.
    w_bcd_shift    = bcd3_t'((w_bcd_adj << 1) | 12'(r_bin[7]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin      <= '0;
      r_bcd      <= '0;
      r_bit_cnt  <= '0;
      r_hold_vld <= 1'b0;
      r_hold_val <= '0;
      r_shown    <= '0;
    end else begin
      if (w_start) begin
        r_bin     <= w_load_val;
        r_bcd     <= '0;
        r_bit_cnt <= '0;
      end else if (r_state == CONV) begin
        r_bin     <= {r_bin[6:0], 1'b0};
        r_bcd     <= w_bcd_shift;
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end

      // The shown digits switch in one step, entering COMMIT.
      if (w_last_bit) begin
        r_shown <= w_bcd_shift;
      end

      // Strobes while busy (COMMIT included) overwrite the single held entry.
      if (result_valid && busy) begin
        r_hold_vld <= 1'b1;
        r_hold_val <= result;
      end else if (w_start) begin
        r_hold_vld <= 1'b0;
      end
    end
  end

  // ---------------- display scan ----------------
  assign w_wrap     = (r_presc == PRESC_LAST);
  assign w_idx_next = w_wrap ? r_idx + 2'd1 : r_idx;
  assign w_refresh  = w_wrap || (r_state == COMMIT);
  assign w_an       = ~(4'b0001 << w_idx_next);

  always_comb begin
    w_digit = r_shown.ones;
    w_blank = 1'b0;
    case (w_idx_next)
      2'd0: w_digit = r_shown.ones;
      2'd1: begin
        w_digit = r_shown.tens;
        w_blank = (r_shown.hund == 4'd0) && (r_shown.tens == 4'd0);
      end
      2'd2: begin
        w_digit = r_shown.hund;
        w_blank = (r_shown.hund == 4'd0);
      end
      default: w_blank = 1'b1;
    endcase
  end

  seg7_decode u_seg7_decode (
    .i_digit (w_digit),
    .i_blank (w_blank),
    .o_seg   (w_seg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= '0;
      r_an    <= 4'b1110;
      r_seg   <= SEG_TABLE[0];
    end else begin
      r_presc <= w_wrap ? '0 : r_presc + DIV_W'(1);
      r_idx   <= w_idx_next;
      if (w_refresh) begin
        r_an  <= w_an;
        r_seg <= w_seg;
      end
    end
  end

  assign an  = r_an;
  assign seg = r_seg;

endmodule
